// File: rtl/buffer_arbiter_if.sv
// buffer_arbiter_if: requester-side request/data bundle and buffered result.
// master = requesters/consumer side, slave = arbiter side.
interface buffer_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 1
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] p;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   s;
  logic               s_valid;
  logic               busy;

  modport master (
    output req, p,
    input  gnt, s, s_valid, busy
  );

  modport slave (
    input  req, p,
    output gnt, s, s_valid, busy
  );
endinterface

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin share of one registered buffer stage among N
// requesters. Ports: clk, reset_n (async low), bus (req,p in; gnt,s,s_valid,busy out).
module buffer_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  buffer_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             sv_q, sv_d;
  logic [IW-1:0]    sel;

  // First requester at or after ptr, wrapping.
  function automatic logic [IW-1:0] scan(
    input logic [N-1:0]  r,
    input logic [IW-1:0] start
  );
    logic [IW-1:0] res;
    logic          hit;
    int            k;
    res = start;
    hit = 1'b0;
    for (int j = 0; j < N; j++) begin
      k = int'(start) + j;
      if (k >= N) k = k - N;
      if (!hit && r[k]) begin
        hit = 1'b1;
        res = IW'(k);
      end
    end
    return res;
  endfunction

  assign sel = scan(bus.req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    sv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_d   = sel;
          gnt_d   = N'(1) << sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.req[idx_q] && (cnt_q < CW'(MAX_HOLD))) begin
          s_d   = bus.p[int'(idx_q)*WIDTH +: WIDTH];
          sv_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          gnt_d   = '0;
          ptr_d   = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      sv_q    <= sv_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s       = s_q;
  assign bus.s_valid = sv_q;
  assign bus.busy    = (state_q == GRANT);
endmodule
